// File: rtl/wptr_full_prog.sv
// Write-side pointer, full/almost-full, occupancy and overflow
// generator for a dual-clock FIFO; read pointer synchronised locally.
module wptr_full_prog #(
  parameter int ADDRSIZE     = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = (1 << ADDRSIZE) - 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr_gray,
  input  logic                clr_ovf,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam int A = ADDRSIZE;
  localparam int W = ADDRSIZE + 1;
  localparam logic [W-1:0] THR = W'(AFULL_THRESH);

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] rq;
  logic [W-1:0] rbin;

  logic [W-1:0] wbin_q, wbin_d;
  logic [W-1:0] wptr_q, wptr_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         full_q, full_d;
  logic         afull_q, afull_d;
  logic         ovf_q, ovf_d;
  logic         wacc;

  assign rq = sync_q[SYNC_STAGES-1];

  // Plain flop chain carrying the read Gray pointer into wclk
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // Gray to binary: each bit is the XOR of itself and all higher bits
  for (genvar i = 0; i < W; i++) begin : g_g2b
    assign rbin[i] = ^(rq >> i);
  end

  // Next-state pointer, flags and occupancy
  always_comb begin
    wacc    = winc & ~full_q;
    wbin_d  = wbin_q + {{A{1'b0}}, wacc};
    wptr_d  = (wbin_d >> 1) ^ wbin_d;
    cnt_d   = wbin_d - rbin;
    full_d  = (wptr_d == {~rq[A:A-1], rq[A-2:0]});
    afull_d = (cnt_d >= THR);
    ovf_d   = (winc & full_q) | (ovf_q & ~clr_ovf);
  end

  // Register every output
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wptr         = wptr_q;
  assign waddr        = wbin_q[A-1:0];
  assign wfull        = full_q;
  assign walmost_full = afull_q;
  assign wcount       = cnt_q;
  assign woverflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_prog.sv
// Directed bench for wptr_full_prog with an occupancy-arithmetic
// reference model checked on every falling edge.
module tb_wptr_full_prog;

  localparam int A    = 8;
  localparam int D    = 1 << A;
  localparam int M    = 2 * D;
  localparam int THR  = D - 4;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         winc = 1'b0;
  logic         clr_ovf = 1'b0;
  logic [A:0]   rd_bin = '0;
  logic [A:0]   rptr_gray;
  logic [A:0]   wptr;
  logic [A-1:0] waddr;
  logic         wfull;
  logic         walmost_full;
  logic [A:0]   wcount;
  logic         woverflow;

  int ncheck = 0;
  int nfail  = 0;

  assign rptr_gray = rd_bin ^ (rd_bin >> 1);

  wptr_full_prog dut (
    .wclk         (clk),
    .wrst_n       (rst_n),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .clr_ovf      (clr_ovf),
    .wptr         (wptr),
    .waddr        (waddr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    ncheck++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & (M - 1);
  endfunction

  // Reference model: counts of accepted writes and the read pointer the
  // write side has seen (SYNC edges of delay), occupancy by subtraction.
  int  m_wb = 0;
  int  m_cnt = 0;
  bit  m_full = 0;
  bit  m_af = 0;
  bit  m_ovf = 0;
  int  hist [SYNC];

  always @(posedge clk or negedge rst_n) begin
    int wb_n;
    int c_n;
    if (!rst_n) begin
      m_wb   <= 0;
      m_cnt  <= 0;
      m_full <= 0;
      m_af   <= 0;
      m_ovf  <= 0;
      for (int i = 0; i < SYNC; i++) hist[i] <= 0;
    end else begin
      wb_n = (m_wb + ((winc && !m_full) ? 1 : 0)) % M;
      c_n  = (wb_n - hist[0] + M) % M;
      m_wb   <= wb_n;
      m_cnt  <= c_n;
      m_full <= (c_n == D);
      m_af   <= (c_n >= THR);
      if (winc && m_full) m_ovf <= 1;
      else if (clr_ovf)   m_ovf <= 0;
      for (int i = 0; i < SYNC - 1; i++) hist[i] <= hist[i+1];
      hist[SYNC-1] <= int'(rd_bin);
    end
  end

  always @(negedge clk) begin
    chk("m_wptr",  int'(wptr),         gray(m_wb));
    chk("m_waddr", int'(waddr),        m_wb % D);
    chk("m_wcount",int'(wcount),       m_cnt);
    chk("m_wfull", int'(wfull),        int'(m_full));
    chk("m_afull", int'(walmost_full), int'(m_af));
    chk("m_ovf",   int'(woverflow),    int'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [A:0] prev;
    bit         wrapped;
    for (int i = 0; i < SYNC; i++) hist[i] = 0;

    // Reset held with writes requested and a moving read pointer
    winc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_bin = 9'(i * 37 + 3);
      tick();
    end
    chk("rst_wptr",   int'(wptr), 0);
    chk("rst_waddr",  int'(waddr), 0);
    chk("rst_wcount", int'(wcount), 0);
    chk("rst_flags",  int'({wfull, walmost_full, woverflow}), 0);
    winc = 1'b0;
    rd_bin = '0;
    tick();
    tick();
    #1 rst_n = 1'b1;
    tick();
    winc = 1'b1;
    tick();
    winc = 1'b0;
    chk("first_wptr",   int'(wptr), 1);
    chk("first_waddr",  int'(waddr), 1);
    chk("first_wcount", int'(wcount), 1);

    // Fill from one entry to full
    winc = 1'b1;
    for (int i = 2; i <= D; i++) begin
      tick();
      chk("fill_cnt",   int'(wcount), i);
      chk("fill_afull", int'(walmost_full), (i >= THR) ? 1 : 0);
      chk("fill_full",  int'(wfull), (i == D) ? 1 : 0);
    end
    chk("full_wptr",  int'(wptr), 'h180);
    chk("full_waddr", int'(waddr), 0);

    // Writes while full
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovf_wptr", int'(wptr), 'h180);
      chk("ovf_set",  int'(woverflow), 1);
    end
    winc = 1'b0;
    clr_ovf = 1'b1;
    tick();
    chk("ovf_clr", int'(woverflow), 0);
    winc = 1'b1;
    tick();
    chk("ovf_setwins", int'(woverflow), 1);
    winc = 1'b0;
    clr_ovf = 1'b0;
    tick();

    // One read observed: flags follow three edges later
    rd_bin = 9'd1;
    tick();
    chk("drain_e1", int'(wfull), 1);
    tick();
    chk("drain_e2", int'(wfull), 1);
    tick();
    chk("drain_full",  int'(wfull), 0);
    chk("drain_cnt",   int'(wcount), D - 1);
    chk("drain_afull", int'(walmost_full), 1);

    // Long run with the reader four writes behind
    rd_bin = 9'(m_wb - 4);
    for (int i = 0; i < 4; i++) tick();
    chk("wrap_start", int'(wcount), 4);
    wrapped = 1'b0;
    winc = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      prev = wptr;
      tick();
      rd_bin = 9'(m_wb - 4);
      chk("wrap_1bit",  $countones(wptr ^ prev), 1);
      chk("wrap_full",  int'(wfull), 0);
      chk("wrap_range", (wcount >= 4 && wcount <= 7) ? 1 : 0, 1);
      if (prev == 9'h100 && wptr == 9'h000) wrapped = 1'b1;
    end
    winc = 1'b0;
    chk("wrap_seen", int'(wrapped), 1);

    // Mid-operation asynchronous reset
    rd_bin = 9'(m_wb - 100);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_cnt", int'(wcount), 100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_wptr",  int'(wptr), 0);
    chk("mid_waddr", int'(waddr), 0);
    chk("mid_cnt0",  int'(wcount), 0);
    chk("mid_flags", int'({wfull, walmost_full, woverflow}), 0);
    rd_bin = '0;
    #1 rst_n = 1'b1;
    tick();
    winc = 1'b1;
    tick();
    winc = 1'b0;
    chk("mid_first", int'(wcount), 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             ncheck, nfail);
    $finish;
  end

endmodule
